// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: select codes, status bit
// positions, sequencer states and the queued command entry layout.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ZERO = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_NOR  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_SHL  = 3'd7
  } alu_sel_e;

  localparam int unsigned ST_V = 3;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_Z = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0]       sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             cin;
    logic             chain;
  } cmd_entry_t;

  localparam int unsigned CMD_W = $bits(cmd_entry_t);

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and response signals of the sequencer; slave is the
// sequencer's view, master is the surrounding system's view.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_cin;
  logic             cmd_chain;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_status;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_out;
  logic [3:0]       rsp_status;
  logic             carry;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_chain,
    input  alu_out, alu_status, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, alu_cin,
    output rsp_valid, rsp_out, rsp_status, carry, busy
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_chain,
    output alu_out, alu_status, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, alu_cin,
    input  rsp_valid, rsp_out, rsp_status, carry, busy
  );
endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers and an occupancy count.
// The caller guarantees no push when full and no pop when empty.
module cmd_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage in front of a combinational ALU: queues commands, drives the
// ALU inputs, captures result/status and returns them on a valid/ready port.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    w_count;
  logic [CMD_W-1:0] w_fifo_q;
  cmd_entry_t       w_head;
  cmd_entry_t       w_push_data;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_capture;
  logic             w_rsp_clr;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_sel;
  logic             r_alu_cin;
  logic [WIDTH-1:0] r_rsp_out;
  logic [3:0]       r_rsp_status;
  logic             r_rsp_valid;
  logic             r_carry;

  assign bus.cmd_ready = (w_count < CW'(DEPTH));
  assign w_push        = bus.cmd_valid && bus.cmd_ready;
  assign w_empty       = (w_count == '0);
  assign w_push_data   = '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b,
                           cin: bus.cmd_cin, chain: bus.cmd_chain};
  assign w_head        = cmd_entry_t'(w_fifo_q);

  cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  if (bus.rsp_ready) w_next = w_empty ? S_IDLE : S_EXEC;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_rsp_clr = 1'b0;
    case (r_state)
      S_IDLE: w_pop = !w_empty;
      S_EXEC: w_capture = 1'b1;
      S_DONE: begin
        w_rsp_clr = bus.rsp_ready;
        w_pop     = bus.rsp_ready && !w_empty;
      end
      default: ;
    endcase
  end

  // Chained pops see r_carry already written by the preceding EXEC capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_alu_cin    <= 1'b0;
      r_rsp_out    <= '0;
      r_rsp_status <= '0;
      r_rsp_valid  <= 1'b0;
      r_carry      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a   <= w_head.a;
        r_alu_b   <= w_head.b;
        r_alu_sel <= w_head.sel;
        r_alu_cin <= w_head.chain ? r_carry : w_head.cin;
      end
      if (w_capture) begin
        r_rsp_out    <= bus.alu_out;
        r_rsp_status <= bus.alu_status;
        r_rsp_valid  <= 1'b1;
        if (r_alu_sel == ALU_ADD) r_carry <= bus.alu_status[ST_C];
      end else if (w_rsp_clr) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.alu_cin    = r_alu_cin;
  assign bus.rsp_out    = r_rsp_out;
  assign bus.rsp_status = r_rsp_status;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.carry      = r_carry;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer against a queue-based
// model of accepted commands and a behavioural 32-bit ALU.
module tb_alu_op_sequencer;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  typedef struct {
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         chain;
  } cmd_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();
  alu_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   tests = 0;
  int   fails = 0;
  cmd_t q[$];
  logic mcarry = 1'b0;
  bit   rand_done;

  function automatic logic [W+3:0] alu_model(input logic [2:0] sel, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (sel)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: r = '0;
      3'd2: r = a ^ b;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = ~(a | b);
      3'd6: r = a >> b[4:0];
      default: r = a << b[4:0];
    endcase
    return {v, c, r[W-1], (r == '0), r};
  endfunction

  assign {bus.alu_status, bus.alu_out} = alu_model(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin);

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Model: q holds accepted, not yet returned commands in issue order.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (q.size() == 0) begin
          timeout("rsp_without_cmd");
        end else begin
          cmd_t       h;
          logic [W+3:0] m;
          h = q.pop_front();
          m = alu_model(h.sel, h.a, h.b, h.chain ? mcarry : h.cin);
          if (h.sel == 3'd0) mcarry = m[W+2];
        end
      end
      if (bus.cmd_valid && bus.cmd_ready)
        q.push_back('{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b,
                      cin: bus.cmd_cin, chain: bus.cmd_chain});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", bus.busy, (q.size() != 0));
      if (q.size() < D)  check("cmd_ready_hi", bus.cmd_ready, 1);
      if (q.size() > D)  check("cmd_ready_lo", bus.cmd_ready, 0);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          timeout("rsp_valid_empty_model");
        end else begin
          cmd_t         h;
          logic         cin;
          logic [W+3:0] m;
          h   = q[0];
          cin = h.chain ? mcarry : h.cin;
          m   = alu_model(h.sel, h.a, h.b, cin);
          check("rsp_out", bus.rsp_out, m[W-1:0]);
          check("rsp_status", bus.rsp_status, m[W+3:W]);
          check("alu_a", bus.alu_a, h.a);
          check("alu_sel", bus.alu_sel, h.sel);
          check("alu_cin", bus.alu_cin, cin);
          check("carry_upd", bus.carry, (h.sel == 3'd0) ? m[W+2] : mcarry);
        end
      end else if (q.size() == 0) begin
        check("carry_idle", bus.carry, mcarry);
      end
    end
  end

  function automatic cmd_t mk(input logic [2:0] sel, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic cin, input logic chain);
    cmd_t c;
    c.sel = sel; c.a = a; c.b = b; c.cin = cin; c.chain = chain;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.sel   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
    c.a     = $urandom;
    c.b     = ($urandom_range(0, 3) == 0) ? ~c.a : $urandom;
    c.cin   = 1'($urandom_range(0, 1));
    c.chain = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    bus.cmd_sel = c.sel; bus.cmd_a = c.a; bus.cmd_b = c.b;
    bus.cmd_cin = c.cin; bus.cmd_chain = c.chain;
  endtask

  task automatic send(input cmd_t c);
    int n = 0;
    drive(c);
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!bus.cmd_ready) timeout("send");
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.rsp_valid) timeout("wait_rsp");
  endtask

  task automatic accept();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 500) begin @(posedge clk); #1; n++; end
    if (bus.busy) timeout("wait_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    logic rb;
    cmd_t bp[6];

    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    drive(mk(3'd0, '0, '0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_rsp_out", bus.rsp_out, 0);
    check("rst_alu_a", bus.alu_a, 0);

    // Latency: accepted at edge k, valid after k+2.
    send(mk(3'd0, 32'd5, 32'd7, 1'b0, 1'b0));
    check("lat_k", bus.rsp_valid, 0);
    @(posedge clk); #1;
    check("lat_k1", bus.rsp_valid, 0);
    check("lat_k1_alu_a", bus.alu_a, 32'd5);
    @(posedge clk); #1;
    check("lat_k2", bus.rsp_valid, 1);
    check("add_out", bus.rsp_out, 32'd12);
    check("add_status", bus.rsp_status, 4'b0000);
    check("add_carry", bus.carry, 0);
    accept();

    // Carry chain and non-add carry preservation.
    send(mk(3'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0));
    wait_rsp();
    check("ovf_out", bus.rsp_out, 32'd0);
    check("ovf_status", bus.rsp_status, 4'b0101);
    check("ovf_carry", bus.carry, 1);
    accept();
    send(mk(3'd0, 32'd0, 32'd0, 1'b0, 1'b1));
    wait_rsp();
    check("chain_cin", bus.alu_cin, 1);
    check("chain_out", bus.rsp_out, 32'd1);
    check("chain_carry", bus.carry, 0);
    accept();
    send(mk(3'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0));
    wait_rsp(); accept();
    send(mk(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0));
    wait_rsp();
    check("xor_out", bus.rsp_out, 32'h0FF00FF0);
    check("xor_carry", bus.carry, 1);
    accept();
    wait_idle(n);

    // Backpressure: six offered, DEPTH+1 accepted.
    for (int i = 0; i < 6; i++) bp[i] = mk(3'd0, 32'(i * 1000 + 1), 32'hFFFFFFFE, 1'b1, 1'(i % 2));
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (idx < 6) begin
        drive(bp[idx]);
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      rb = bus.cmd_ready;
      @(posedge clk); #1;
      if (rb && idx < 6) idx++;
    end
    bus.cmd_valid = 1'b0;
    check("bp_accepted", idx, 5);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    bus.rsp_ready = 1'b1;
    wait_idle(n);
    check("bp_drain_cycles", n, 9);
    check("bp_model_empty", q.size(), 0);

    // Wrap-around: 12 back-to-back with rsp_ready high.
    for (int i = 0; i < 12; i++) send(rand_cmd());
    wait_idle(n);
    check("wrap_model_empty", q.size(), 0);

    // Random traffic with random response backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rand_cmd());
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle(n);
    check("rand_model_empty", q.size(), 0);

    // Asynchronous reset while in DONE with three queued.
    send(mk(3'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0));
    wait_idle(n);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(3'd3, 32'(i + 10), 32'hFF, 1'b0, 1'b0));
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_carry", bus.carry, 1);
    #2 rst = 1'b1;
    q.delete();
    mcarry = 1'b0;
    #1;
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_out", bus.rsp_out, 0);
    check("arst_rsp_status", bus.rsp_status, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_carry", bus.carry, 0);
    check("arst_cmd_ready", bus.cmd_ready, 1);
    check("arst_alu_a", bus.alu_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    send(mk(3'd0, 32'd5, 32'd7, 1'b1, 1'b1));
    wait_rsp();
    check("post_rst_cin", bus.alu_cin, 0);
    check("post_rst_out", bus.rsp_out, 32'd12);
    check("post_rst_carry", bus.carry, 0);
    accept();
    wait_idle(n);
    check("post_rst_model_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side issue stage that sits directly upstream of the 32-bit combinational ALU. It buffers ALU commands in a small FIFO and registers operands, select and carry-in onto the ALU inputs. It captures the ALU result and status one cycle later and returns them over a valid/ready response handshake. It also keeps a carry register so that multi-word additions can be chained without software reading flags.

## Interface
- WIDTH, 32, operand/result width; must match the ALU (32).
- DEPTH, 4, command FIFO entries (power of two, ≥2).

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (count < DEPTH)
- cmd_sel  in  3  ALU select
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_cin  in  1  explicit carry-in
- cmd_chain  in  1  1 = use stored carry register instead of cmd_cin
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_sel  out  3  registered select to ALU
- alu_cin  out  1  registered carry-in to ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_* outputs)
- alu_status  in  4  ALU flags {V,C,N,Z}
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_out  out  WIDTH  captured result
- rsp_status  out  4  captured raw status
- carry  out  1  current carry register
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Push: FIFO write on cmd_valid & cmd_ready. The entry is {sel, a, b, cin, chain}. cmd_ready depends only on count, with no full-bypass.
- FSM states: IDLE, EXEC, DONE.
  - IDLE, FIFO non-empty: pop and load the alu_* regs; alu_cin = chain ? carry : cin; go to EXEC.
  - EXEC: always lasts one cycle. At its closing edge, capture alu_out into rsp_out and alu_status into rsp_status, set rsp_valid, go to DONE.
  - If the EXEC sel = 3'b000 (add), carry ← alu_status[2] at the same edge. Other selects leave carry unchanged.
  - DONE: hold rsp_* stable while rsp_valid & !rsp_ready.
  - DONE, rsp_ready: clear rsp_valid. If the FIFO is non-empty, pop the next entry on the same edge and go to EXEC; otherwise go to IDLE.
- Chained pop reads the carry already updated by the previous capture.
- alu_* regs hold their last values when not loading.
- Push and pop in the same cycle: count unchanged.
- Push into an empty FIFO: that entry is not poppable until the following cycle.
- Reset (any time, including mid-EXEC/DONE):
  - FIFO emptied, state IDLE, carry 0, rsp_valid 0, rsp_out/rsp_status 0, alu_* 0, busy 0, cmd_ready 1.
  - In-flight commands are discarded.

## Timing
- Latency: command accepted at edge k with FSM idle and FIFO empty → pop at k+1 → rsp_valid high after edge k+2.
- Throughput: one result per 2 cycles with rsp_ready held high.
- ALU path is a single-cycle combinational loop alu_* → alu_out → rsp regs. No ALU path crosses DONE.
- Maximum accepted before backpressure with rsp_ready=0: DEPTH+1 (one in flight, DEPTH queued).

## Structure
- Shared package alu_pkg:
  - select encodings: ADD=0, ZERO=1, XOR=2, AND=3, OR=4, NOR=5, SHR=6, SHL=7
  - status bit indices: V=3, C=2, N=1, Z=0
  - FSM state enum
  - command-entry struct/width
- Sub-module cmd_fifo: synchronous, parameterised width/depth, count output, wrap-around pointers.
- FSM and capture registers live in alu_op_sequencer.

## Test plan
- ADD: a=5, b=7, cin=0 accepted at edge k → rsp_valid after k+2, rsp_out=12, rsp_status=4'b0000, carry=0.
- Carry chain:
  - ADD a=32'hFFFFFFFF, b=1 → rsp_out=0, rsp_status=4'b0101, carry=1.
  - Then ADD a=0, b=0, chain=1 → alu_cin=1, rsp_out=1, carry=0.
- Non-add preserves carry: after carry=1, XOR a=32'hF0F0F0F0, b=32'hFF00FF00 → rsp_out=32'h0FF00FF0, carry still 1.
- Backpressure: rsp_ready=0, cmd_valid held with 6 commands → exactly 5 accepted, then cmd_ready=0. Releasing rsp_ready drains all 5 in order, one per 2 cycles, with no loss or duplication.
- Wrap-around: 12 back-to-back commands with rsp_ready=1 (DEPTH=4) → results in issue order with correct values.
- Reset mid-op: assert rst while in DONE with 3 queued → all outputs take reset values immediately (asynchronous), busy=0. The next command after deassertion completes normally with carry=0.
